seg7_mux_display: RTL and testbench



---
 rtl/seg7_mux_display.sv | 204 ++++++++++++++++++++
 tb/tb_seg7_mux_display.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_mux_display.sv
`default_nettype none
// ============================================================================
// Module   : seg7_mux_display
// Brief    : N-digit multiplexed 7-segment driver. It converts binary to BCD
//            serially and scans the digits with a dwell and a blanking gap.
//            Optional leading-zero blanking: define SEG7_LZB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_mux_display #(
   parameter int DIGITS          = 4,
   parameter int WIDTH           = 14,
   parameter int SCAN_DIV        = 16,
   parameter int BLANK_CYCLES    = 64,
   parameter int SEG_ACTIVE_LOW  = 1,
   parameter int DIG_ACTIVE_HIGH = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [WIDTH-1:0]  value,
   input  logic [DIGITS-1:0] dp,
   input  logic              value_valid,
   output logic              busy,
   output logic [7:0]        seg,
   output logic [DIGITS-1:0] dig
);

   localparam int                  c_IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int                  c_CW       = $clog2(WIDTH + 1);
   localparam int                  c_BW       = 4 * DIGITS;
   localparam logic [63:0]         c_MAXV     = 64'(10 ** DIGITS) - 64'd1;
   localparam logic [c_CW-1:0]     c_LAST     = c_CW'(WIDTH - 1);
   localparam logic [c_IW-1:0]     c_IDX_LAST = c_IW'(DIGITS - 1);
   localparam logic [SCAN_DIV-1:0] c_BLANK    = SCAN_DIV'(BLANK_CYCLES);
   localparam logic [7:0]          c_SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [DIGITS-1:0]   c_DIG_OFF  = (DIG_ACTIVE_HIGH != 0) ?
                                                {DIGITS{1'b0}} : {DIGITS{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    bin_q, bin_d;
   logic [c_BW-1:0]     bcd_q, bcd_d;
   logic [c_CW-1:0]     cnt_q, cnt_d;
   logic [DIGITS-1:0]   dpc_q, dpc_d;
   logic                ovfc_q, ovfc_d;
   logic [c_BW-1:0]     disp_bcd_q, disp_bcd_d;
   logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
   logic                disp_ovf_q, disp_ovf_d;
   logic [SCAN_DIV-1:0] pre_q, pre_d;
   logic [c_IW-1:0]     idx_q, idx_d;
   logic [7:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   dig_q, dig_d;

   logic [c_BW-1:0]     w_adj;
   logic [DIGITS-1:0]   w_blank;
   logic [3:0]          w_nib;
   logic                w_dpbit;
   logic [7:0]          w_raw;

   function automatic logic [6:0] f_pat(input logic [3:0] n);
      case (n)
         4'd0:    f_pat = 7'h3F;
         4'd1:    f_pat = 7'h06;
         4'd2:    f_pat = 7'h5B;
         4'd3:    f_pat = 7'h4F;
         4'd4:    f_pat = 7'h66;
         4'd5:    f_pat = 7'h6D;
         4'd6:    f_pat = 7'h7D;
         4'd7:    f_pat = 7'h07;
         4'd8:    f_pat = 7'h7F;
         4'd9:    f_pat = 7'h6F;
         default: f_pat = 7'h00;
      endcase
   endfunction

   always_comb begin
      w_adj = '0;
      for (int k = 0; k < DIGITS; k++) begin
         w_adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                       : bcd_q[4*k +: 4];
      end
   end

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      dpc_d      = dpc_q;
      ovfc_d     = ovfc_q;
      disp_bcd_d = disp_bcd_q;
      disp_dp_d  = disp_dp_q;
      disp_ovf_d = disp_ovf_q;
      case (state_q)
         S_IDLE: begin
            if (value_valid) begin
               bin_d   = value;
               bcd_d   = '0;
               cnt_d   = '0;
               dpc_d   = dp;
               ovfc_d  = (64'(value) > c_MAXV);
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            bcd_d  = {w_adj[c_BW-2:0], bin_q[WIDTH-1]};
            bin_d  = bin_q << 1;
            cnt_d  = cnt_q + c_CW'(1);
            // A bit leaving the top nibble also means the value is out of range
            ovfc_d = ovfc_q | w_adj[c_BW-1];
            if (cnt_q == c_LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            disp_bcd_d = bcd_q;
            disp_dp_d  = ovfc_q ? '0 : dpc_q;
            disp_ovf_d = ovfc_q;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef SEG7_LZB_EN
   always_comb begin
      logic hi_zero;
      hi_zero = 1'b1;
      w_blank = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         hi_zero    = hi_zero && (disp_bcd_q[4*k +: 4] == 4'd0);
         w_blank[k] = (k != 0) && hi_zero;
      end
   end
`else
   assign w_blank = '0;
`endif

   always_comb begin
      pre_d   = pre_q + SCAN_DIV'(1);
      idx_d   = idx_q;
      if (pre_q == {SCAN_DIV{1'b1}}) begin
         idx_d = (idx_q == c_IDX_LAST) ? '0 : idx_q + c_IW'(1);
      end
      w_nib   = disp_bcd_q[{idx_q, 2'b00} +: 4];
      w_dpbit = disp_dp_q[idx_q];
      if (disp_ovf_q) begin
         w_raw = 8'h40;
      end else if (w_blank[idx_q]) begin
         w_raw = {w_dpbit, 7'h00};
      end else begin
         w_raw = {w_dpbit, f_pat(w_nib)};
      end
      if (pre_q < c_BLANK) begin
         seg_d = c_SEG_OFF;
         dig_d = c_DIG_OFF;
      end else begin
         seg_d = w_raw ^ c_SEG_OFF;
         dig_d = (DIGITS'(1) << idx_q) ^ c_DIG_OFF;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         dpc_q      <= '0;
         ovfc_q     <= 1'b0;
         disp_bcd_q <= '0;
         disp_dp_q  <= '0;
         disp_ovf_q <= 1'b0;
         pre_q      <= '0;
         idx_q      <= '0;
         seg_q      <= c_SEG_OFF;
         dig_q      <= c_DIG_OFF;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         dpc_q      <= dpc_d;
         ovfc_q     <= ovfc_d;
         disp_bcd_q <= disp_bcd_d;
         disp_dp_q  <= disp_dp_d;
         disp_ovf_q <= disp_ovf_d;
         pre_q      <= pre_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
         dig_q      <= dig_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign seg  = seg_q;
   assign dig  = dig_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_mux_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_mux_display
// Brief    : Scoreboard bench for seg7_mux_display (4 digits, short dwell).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_mux_display;

   localparam int DIGITS = 4;
   localparam int WIDTH  = 14;
   localparam int SDIV   = 4;
   localparam int BLANK  = 2;
   localparam int DWELL  = 1 << SDIV;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic [WIDTH-1:0]  value = '0;
   logic [DIGITS-1:0] dp = '0;
   logic              value_valid = 1'b0;
   logic              busy;
   logic [7:0]        seg;
   logic [DIGITS-1:0] dig;

   always #5 CLK = ~CLK;

   seg7_mux_display #(
      .DIGITS(DIGITS), .WIDTH(WIDTH), .SCAN_DIV(SDIV), .BLANK_CYCLES(BLANK),
      .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_HIGH(1)
   ) dut (
      .CLK(CLK), .RST(RST), .value(value), .dp(dp), .value_valid(value_valid),
      .busy(busy), .seg(seg), .dig(dig)
   );

   typedef struct {
      int          busy_len;
      logic [31:0] frame;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   n_edges  = 0;

   // Edges since reset was last released
   always @(posedge CLK) n_edges <= RST ? 0 : n_edges + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] pat(input int d);
      case (d)
         0: pat = 7'h3F;  1: pat = 7'h06;  2: pat = 7'h5B;  3: pat = 7'h4F;
         4: pat = 7'h66;  5: pat = 7'h6D;  6: pat = 7'h7D;  7: pat = 7'h07;
         8: pat = 7'h7F;  9: pat = 7'h6F;  default: pat = 7'h00;
      endcase
   endfunction

   // Pin-level seg byte for each digit slot, packed as 8 bits per digit
   function automatic logic [31:0] model_frame(input int v, input logic [3:0] d);
      logic [31:0] f;
      logic [7:0]  raw;
      int          p10;
      f   = '0;
      p10 = 1;
      for (int k = 0; k < DIGITS; k++) begin
         if (v > 9999) begin
            raw = 8'h40;
         end else begin
            raw = {d[k], pat((v / p10) % 10)};
`ifdef SEG7_LZB_EN
            if (k > 0 && v < p10) raw = {d[k], 7'h00};
`endif
         end
         f[8*k +: 8] = ~raw;
         p10 = p10 * 10;
      end
      return f;
   endfunction

   initial begin : monitor
      logic [31:0] cur, nxt;
      logic [3:0]  edig;
      logic [7:0]  eseg;
      bit          apply;
      int          run, p, i;
      exp_t        e;
      cur   = model_frame(0, 4'b0000);
      nxt   = cur;
      apply = 0;
      run   = 0;
      forever begin
         @(negedge CLK);
         if (apply) begin
            cur   = nxt;
            apply = 0;
         end
         if (n_edges == 0) begin
            chk("reset_seg", {24'd0, seg}, 32'hFF);
            chk("reset_dig", {28'd0, dig}, 32'h0);
            chk("reset_busy", {31'd0, busy}, 32'h0);
         end else begin
            p = (n_edges - 1) % DWELL;
            i = ((n_edges - 1) / DWELL) % DIGITS;
            if (p < BLANK) begin
               edig = 4'b0000;
               eseg = 8'hFF;
            end else begin
               edig = 4'b0001 << i;
               eseg = cur[8*i +: 8];
            end
            chk("scan_dig", {28'd0, dig}, {28'd0, edig});
            chk("scan_seg", {24'd0, seg}, {24'd0, eseg});
         end
         if (busy) begin
            run++;
         end else if (run > 0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_busy_run", run, 0);
            end else begin
               e = exp_q.pop_front();
               chk("busy_len", run, e.busy_len);
               nxt   = e.frame;
               apply = 1;
            end
            run = 0;
         end
      end
   end

   task automatic do_load(input int v, input logic [3:0] d, input int ig_at,
                          input int ig_val, input int rst_at);
      exp_t e;
      int   t;
      value       = WIDTH'(v);
      dp          = d;
      value_valid = 1'b1;
      e.busy_len  = (rst_at > 0) ? rst_at : WIDTH + 1;
      e.frame     = (rst_at > 0) ? model_frame(0, 4'b0000) : model_frame(v, d);
      exp_q.push_back(e);
      @(negedge CLK);
      value_valid = 1'b0;
      for (int k = 1; k <= WIDTH + 2; k++) begin
         if (k == ig_at) begin
            value       = WIDTH'(ig_val);
            value_valid = 1'b1;
         end
         if (ig_at > 0 && k == ig_at + 1) value_valid = 1'b0;
         if (k == rst_at) RST = 1'b1;
         if (rst_at > 0 && k == rst_at + 1) RST = 1'b0;
         @(negedge CLK);
      end
      t = 0;
      while (busy && t < 100) begin
         @(negedge CLK);
         t++;
      end
      chk("busy_timeout", {31'd0, busy}, 32'h0);
      repeat (DIGITS * DWELL + 16) @(negedge CLK);
   endtask

   initial begin : stimulus
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      repeat (DIGITS * DWELL + 16) @(negedge CLK);
      do_load(1234,  4'b0100, 0, 0,    0);
      do_load(12000, 4'b1111, 0, 0,    0);
      do_load(5,     4'b0000, 0, 0,    0);
      do_load(7,     4'b0000, 0, 0,    0);
      do_load(42,    4'b0000, 5, 9999, 0);
      do_load(1234,  4'b0001, 0, 0,    0);
      do_load(5678,  4'b1111, 0, 0,    8);
      do_load(0,     4'b1010, 0, 0,    0);
      do_load(9999,  4'b0000, 0, 0,    0);
      do_load(10000, 4'b0000, 0, 0,    0);
      for (int r = 0; r < 8; r++) begin
         int v, ig;
         logic [3:0] d;
         v  = int'($urandom_range(0, 16383));
         d  = 4'($urandom_range(0, 15));
         ig = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 13)) : 0;
         do_load(v, d, ig, int'($urandom_range(0, 16383)), 0);
      end
      repeat (5) @(negedge CLK);
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule
`default_nettype wire
